pipeline_hazard_controller: RTL and testbench

- Central stall/flush/freeze sequencer for the 5-stage ARM pipeline.
- Keeps its own 2-slot destination scoreboard (EXE, MEM) of instructions it has let issue from ID, and raises the ID `hazard` stall on read-after-write conflicts.
- Freezes the whole pipeline while a multi-cycle data-memory access completes.
- Flushes IF/ID and ID/EXE on a taken branch.
- Counts stall cycles for performance debug.

---
 rtl/pipeline_hazard_controller.sv | 115 +++++++++++
 tb/tb_pipeline_hazard_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/freeze sequencer for the 5-stage pipeline: RAW scoreboard, memory freeze FSM, branch flush.
// Outputs are combinational from state + inputs (0 cycles); pipe_freeze holds every stage, hazard bubbles ID.
module pipeline_hazard_controller #(
  parameter int MEM_LAT = 4,
  parameter int FWD_EN  = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_two_src,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  input  logic             mem_access,
  input  logic             exe_branch_taken,
  output logic             hazard,
  output logic             pipe_freeze,
  output logic             flush,
  output logic             mem_done,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] dest;
    logic       is_load;
  } slot_t;

  localparam bit         MULTI     = (MEM_LAT > 1);
  localparam bit         SKIP_WAIT = (MEM_LAT == 2);
  // cnt holds the number of WAIT cycles still to come after the current one
  localparam logic [3:0] WAIT_INIT = 4'((MEM_LAT >= 3) ? (MEM_LAT - 3) : 0);

  state_t     state;
  logic [3:0] cnt;
  slot_t      exe_slot;
  logic       mem_vld;
  logic [3:0] mem_dest;

  logic start, freeze_raw, done_raw;
  logic match_exe, match_mem, raw, issued;

  always_comb begin
    start      = (state == IDLE) & mem_access;
    freeze_raw = (state == WAIT) | (start & MULTI);
    done_raw   = (state == DONE) | (start & ~MULTI);

    match_exe = exe_slot.valid &
                ((id_src1 == exe_slot.dest) | (id_two_src & (id_src2 == exe_slot.dest)));
    match_mem = mem_vld &
                ((id_src1 == mem_dest) | (id_two_src & (id_src2 == mem_dest)));

    if (FWD_EN != 0) raw = id_valid & match_exe & exe_slot.is_load;
    else             raw = id_valid & (match_exe | match_mem);

    pipe_freeze = rst & freeze_raw;
    flush       = rst & exe_branch_taken & ~freeze_raw;
    hazard      = rst & raw & ~freeze_raw & ~exe_branch_taken;
    mem_done    = rst & done_raw;
    issued      = id_valid & ~hazard & ~flush;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_access && MULTI) begin
            if (SKIP_WAIT) begin
              state <= DONE;
            end else begin
              state <= WAIT;
              cnt   <= WAIT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else             cnt   <= cnt - 4'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The MEM slot only feeds the non-forwarding RAW check, so its load flag is not kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_slot <= '0;
      mem_vld  <= 1'b0;
      mem_dest <= 4'd0;
    end else if (!pipe_freeze) begin
      mem_vld  <= exe_slot.valid;
      mem_dest <= exe_slot.dest;
      exe_slot <= '{valid: issued & id_wb_en, dest: id_dest, is_load: id_mem_r_en};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if ((hazard || pipe_freeze) && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Bench for pipeline_hazard_controller: four instances (lat4/no-fwd, lat4/fwd, lat1, lat4 with 3-bit counter).
module tb_pipeline_hazard_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_two_src, id_wb_en, id_mem_r_en, mem_access, exe_branch_taken;
  logic [3:0] id_src1, id_src2, id_dest;

  logic hz_a, fz_a, fl_a, dn_a;
  logic hz_b, fz_b, fl_b, dn_b;
  logic hz_c, fz_c, fl_c, dn_c;
  logic hz_d, fz_d, fl_d, dn_d;
  logic [15:0] cnt_a, cnt_b, cnt_c;
  logic [2:0]  cnt_d;

  pipeline_hazard_controller #(.MEM_LAT(4), .FWD_EN(0), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .mem_access(mem_access), .exe_branch_taken(exe_branch_taken),
    .hazard(hz_a), .pipe_freeze(fz_a), .flush(fl_a), .mem_done(dn_a), .stall_cycles(cnt_a));

  pipeline_hazard_controller #(.MEM_LAT(4), .FWD_EN(1), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .mem_access(mem_access), .exe_branch_taken(exe_branch_taken),
    .hazard(hz_b), .pipe_freeze(fz_b), .flush(fl_b), .mem_done(dn_b), .stall_cycles(cnt_b));

  pipeline_hazard_controller #(.MEM_LAT(1), .FWD_EN(0), .CNT_W(16)) dut_c (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .mem_access(mem_access), .exe_branch_taken(exe_branch_taken),
    .hazard(hz_c), .pipe_freeze(fz_c), .flush(fl_c), .mem_done(dn_c), .stall_cycles(cnt_c));

  pipeline_hazard_controller #(.MEM_LAT(4), .FWD_EN(0), .CNT_W(3)) dut_d (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .mem_access(mem_access), .exe_branch_taken(exe_branch_taken),
    .hazard(hz_d), .pipe_freeze(fz_d), .flush(fl_d), .mem_done(dn_d), .stall_cycles(cnt_d));

  typedef struct {
    logic       rst, vl;
    logic [3:0] s1, s2;
    logic       two, wb, mr;
    logic [3:0] dest;
    logic       ma, br;
    logic       hz, fz, fl, dn;
    int         cnt;
    logic       hz_b;
    logic       chk_b;
    int         id;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, vl, input logic [3:0] s1, s2,
                              input logic two, wb, mr, input logic [3:0] dest,
                              input logic ma, br, hz, fz, fl, dn, input int cnt);
    vec_t t;
    t.rst = r;  t.vl = vl; t.s1 = s1; t.s2 = s2; t.two = two; t.wb = wb; t.mr = mr;
    t.dest = dest; t.ma = ma; t.br = br; t.hz = hz; t.fz = fz; t.fl = fl; t.dn = dn;
    t.cnt = cnt; t.hz_b = 1'b0; t.chk_b = 1'b0; t.id = 0;
    return t;
  endfunction

  function automatic vec_t with_b(input vec_t t, input logic hb);
    vec_t r;
    r = t;
    r.hz_b  = hb;
    r.chk_b = 1'b1;
    return r;
  endfunction

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0d expected %0d", nm, id, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int id);
    vec_t e;
    int   exp_d;
    rst = t.rst; id_valid = t.vl; id_src1 = t.s1; id_src2 = t.s2; id_two_src = t.two;
    id_wb_en = t.wb; id_mem_r_en = t.mr; id_dest = t.dest;
    mem_access = t.ma; exe_branch_taken = t.br;
    t.id = id;
    sb.push_back(t);
    @(negedge clk);
    e = sb.pop_front();
    chk("hazard",      e.id, {31'd0, hz_a}, {31'd0, e.hz});
    chk("pipe_freeze", e.id, {31'd0, fz_a}, {31'd0, e.fz});
    chk("flush",       e.id, {31'd0, fl_a}, {31'd0, e.fl});
    chk("mem_done",    e.id, {31'd0, dn_a}, {31'd0, e.dn});
    if (e.cnt >= 0) begin
      exp_d = (e.cnt > 7) ? 7 : e.cnt;
      chk("stall_cycles",     e.id, {16'd0, cnt_a}, e.cnt);
      chk("stall_cycles_sat", e.id, {29'd0, cnt_d}, exp_d);
    end
    if (e.chk_b) chk("hazard_fwd", e.id, {31'd0, hz_b}, {31'd0, e.hz_b});
    chk("lat1_freeze", e.id, {31'd0, fz_c}, 32'd0);
    chk("lat1_done",   e.id, {31'd0, dn_c}, {31'd0, e.rst & e.ma});
    chk("lat1_flush",  e.id, {31'd0, fl_c}, {31'd0, e.rst & e.br});
    @(posedge clk);
    #1;
  endtask

  initial begin
    // rst vl s1 s2 two wb mr dest ma br | hz fz fl dn cnt
    tbl.push_back(mk(0,1,0,0,0,0,0,0, 1,1, 0,0,0,0, 0));  // reset holds outputs low
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,1, 0,1,0,0, 0));  // freeze on first cycle after release
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,1, 3));  // DONE
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 3));
    tbl.push_back(mk(1,1,0,0,0,1,0,2, 0,0, 0,0,0,0, 3));  // ADD R2
    tbl.push_back(mk(1,1,2,0,0,1,0,5, 0,0, 1,0,0,0, 3));  // RAW on EXE
    tbl.push_back(mk(1,1,2,0,0,1,0,5, 0,0, 1,0,0,0, 4));  // RAW on MEM
    tbl.push_back(mk(1,1,2,0,0,1,0,5, 0,0, 0,0,0,0, 5));  // issues
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 5));
    tbl.push_back(mk(1,1,5,0,0,1,0,6, 0,1, 0,0,1,0, 5));  // RAW + branch: flush wins
    tbl.push_back(mk(1,1,6,0,0,0,0,0, 0,0, 0,0,0,0, 5));  // flushed R6 never recorded
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 5));
    tbl.push_back(mk(1,1,0,0,0,1,0,7, 0,0, 0,0,0,0, 5));  // writer R7
    tbl.push_back(mk(1,1,7,0,0,1,0,8, 1,1, 0,1,0,0, 5));  // branch + RAW during freeze
    tbl.push_back(mk(1,1,7,0,0,1,0,8, 1,1, 0,1,0,0, 6));
    tbl.push_back(mk(1,1,7,0,0,1,0,8, 1,1, 0,1,0,0, 7));
    tbl.push_back(mk(1,1,7,0,0,1,0,8, 1,1, 0,0,1,1, 8));  // DONE: flush, hazard masked
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 8));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 8));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 9));
    tbl.push_back(mk(0,0,0,0,0,0,0,0, 1,0, 0,0,0,0, 0));  // reset mid-WAIT
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 0));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 0));  // back-to-back loads
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 1));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 2));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,1, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 3));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 4));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,1,0,0, 5));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 1,0, 0,0,0,1, 6));
    tbl.push_back(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 6));

    foreach (tbl[i]) apply(tbl[i], i);

    // Forwarding: load-use stalls once; a non-load writer never stalls
    apply(mk(0,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 0), 100);
    apply(with_b(mk(1,1,0,0,0,1,1,3, 0,0, 0,0,0,0, 0), 1'b0), 101);  // LDR R3
    apply(with_b(mk(1,1,0,3,1,1,0,4, 0,0, 1,0,0,0, 0), 1'b1), 102);  // ADD uses R3
    apply(with_b(mk(1,1,0,3,1,1,0,4, 0,0, 1,0,0,0, 1), 1'b0), 103);
    apply(with_b(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 2), 1'b0), 104);
    apply(with_b(mk(1,0,0,0,0,0,0,0, 0,0, 0,0,0,0, 2), 1'b0), 105);
    apply(with_b(mk(1,1,0,0,0,1,0,3, 0,0, 0,0,0,0, 2), 1'b0), 106);  // ADD R3
    apply(with_b(mk(1,1,0,3,1,1,0,9, 0,0, 1,0,0,0, 2), 1'b0), 107);
    apply(with_b(mk(1,1,0,3,0,0,0,0, 0,0, 0,0,0,0, 3), 1'b0), 108);  // src2 ignored

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
